// File: rtl/sram_line_requester_pkg.sv
// ============================================================================
//  Module   : sram_line_requester_pkg
//  Purpose  : Shared widths, line-offset mask, FSM state encoding and a
//             line-base helper for the SRAM line requester.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_line_requester_pkg;

    localparam int c_line_w = 256;                  // one cache line
    localparam int c_addr_w = 20;                   // word address width
    localparam logic [c_addr_w-1:0] c_line_mask = 20'hF_FFF8;  // clears word-in-line bits

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_GAP  = 2'd3
    } req_state_t;

    function automatic logic [c_addr_w-1:0] line_base(input logic [c_addr_w-1:0] a);
        return a & c_line_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_line_requester_wbuf.sv
// ============================================================================
//  Module   : line_wbuf
//  Purpose  : FIFO of {line address, line data} with a parallel address
//             compare against every valid entry. Reports whether any entry
//             matches and returns the data of the youngest matching entry.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             i_push/_addr/_data - enqueue (caller guarantees not full)
//             i_pop              - drop the head entry
//             i_match_addr       - line address to compare
//             o_head_addr/_data  - oldest entry
//             o_count, o_empty   - occupancy
//             o_hit, o_hit_data  - any match / youngest matching data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_wbuf
    import sram_line_requester_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [c_addr_w-1:0]   i_push_addr,
    input  logic [c_line_w-1:0]   i_push_data,
    input  logic                  i_pop,
    input  logic [c_addr_w-1:0]   i_match_addr,
    output logic [c_addr_w-1:0]   o_head_addr,
    output logic [c_line_w-1:0]   o_head_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                  o_empty,
    output logic                  o_hit,
    output logic [c_line_w-1:0]   o_hit_data
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_addr_w-1:0] r_addr [DEPTH];
    logic [c_line_w-1:0] r_data [DEPTH];
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w:0]    r_count;

    logic [DEPTH-1:0]    w_match_vec;   // bit i = i-th oldest entry matches
    logic [c_ptr_w-1:0]  w_idx;
    logic [c_ptr_w-1:0]  w_hit_idx;

    // Storage carries no reset: validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk entries oldest to youngest so the last hit seen is the youngest.
    always_comb begin
        w_match_vec = '0;
        w_hit_idx   = r_rd_ptr;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx          = r_rd_ptr + c_ptr_w'(i);
            w_match_vec[i] = ((c_ptr_w+1)'(i) < r_count) && (r_addr[w_idx] == i_match_addr);
            if (w_match_vec[i]) w_hit_idx = w_idx;
        end
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_hit       = |w_match_vec;
    assign o_hit_data  = r_data[w_hit_idx];

endmodule

`default_nettype wire

// File: rtl/sram_line_requester.sv
// ============================================================================
//  Module   : sram_line_requester
//  Purpose  : Cache-side initiator for the SRAM line controller. Buffers
//             write-through lines, accepts refill reads and serialises both
//             into single-line controller transactions, one GAP cycle apart.
//  Config   : SRAM_REQ_WBUF_FWD_EN - when defined, a read hitting a buffered
//             line is served from the youngest matching entry without an
//             SRAM access; otherwise the buffer drains until no entry matches.
//  Ports    : clk, rst                         - clock, sync active-high reset
//             i_rd_req/i_rd_addr, o_rd_ready   - refill request handshake
//             o_rd_valid, o_rd_data            - refill return (1-cycle pulse)
//             i_wr_req/_addr/_data, o_wr_ready - line write into the buffer
//             i_abort                          - cancel outstanding read
//             o_wbuf_empty                     - no buffered/in-flight writes
//             o_mem_*                          - controller request side
//             i_mem_read_finish/_write_finish, i_mem_rdata - controller return
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_line_requester
    import sram_line_requester_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rd_req,
    input  logic [c_addr_w-1:0] i_rd_addr,
    output logic                o_rd_ready,
    output logic                o_rd_valid,
    output logic [c_line_w-1:0] o_rd_data,
    input  logic                i_wr_req,
    input  logic [c_addr_w-1:0] i_wr_addr,
    input  logic [c_line_w-1:0] i_wr_data,
    output logic                o_wr_ready,
    input  logic                i_abort,
    output logic                o_wbuf_empty,
    output logic                o_mem_addr_valid,
    output logic                o_mem_we,
    output logic                o_mem_flush,
    output logic [c_addr_w-1:0] o_mem_addr,
    output logic [c_line_w-1:0] o_mem_wdata,
    input  logic                i_mem_read_finish,
    input  logic                i_mem_write_finish,
    input  logic [c_line_w-1:0] i_mem_rdata
);

    localparam int c_cnt_w = $clog2(WBUF_DEPTH) + 1;

    req_state_t          r_state, w_state_nxt;
    logic [c_addr_w-1:0] r_mem_addr;
    logic                r_mem_we;
    logic [c_line_w-1:0] r_mem_wdata;
    logic [c_line_w-1:0] r_rd_data;
    logic                r_rd_valid;

    logic [c_addr_w-1:0] w_rd_line, w_wr_line, w_head_addr, w_drain_addr;
    logic [c_line_w-1:0] w_head_data, w_hit_data, w_fwd_data, w_drain_data;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_fifo_empty, w_fifo_hit, w_full, w_push, w_pop;
    logic                w_new_hit, w_conflict, w_rd_pend, w_have_wr;
    logic                w_rd_ready, w_load_rd, w_load_wr, w_rd_cap, w_fwd;
    logic                w_addr_valid, w_flush;

    assign w_rd_line = line_base(i_rd_addr);
    assign w_wr_line = line_base(i_wr_addr);
    assign w_full    = (w_count == c_cnt_w'(WBUF_DEPTH));
    assign w_push    = i_wr_req & ~w_full;
    assign w_pop     = (r_state == ST_WR) & i_mem_write_finish;

    line_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_addr  (w_wr_line),
        .i_push_data  (i_wr_data),
        .i_pop        (w_pop),
        .i_match_addr (w_rd_line),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_count      (w_count),
        .o_empty      (w_fifo_empty),
        .o_hit        (w_fifo_hit),
        .o_hit_data   (w_hit_data)
    );

    // A write arriving this cycle is logically ahead of the read, so it takes
    // part in the conflict check and is the youngest candidate for forwarding.
    assign w_new_hit  = w_push & (w_wr_line == w_rd_line);
    assign w_conflict = w_fifo_hit | w_new_hit;
    assign w_fwd_data = w_new_hit ? i_wr_data : w_hit_data;

    // An abort while idle simply keeps a not-yet-accepted read from starting.
    assign w_rd_pend  = i_rd_req & ~i_abort;
    assign w_have_wr  = ~w_fifo_empty | w_push;

    // With an empty FIFO the write being pushed right now is the head.
    assign w_drain_addr = w_fifo_empty ? w_wr_line : w_head_addr;
    assign w_drain_data = w_fifo_empty ? i_wr_data : w_head_data;

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ready   = 1'b0;
        w_load_rd    = 1'b0;
        w_load_wr    = 1'b0;
        w_rd_cap     = 1'b0;
        w_fwd        = 1'b0;
        w_addr_valid = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_pend && !w_conflict) begin
                    w_state_nxt = ST_RD;
                    w_rd_ready  = 1'b1;
                    w_load_rd   = 1'b1;
`ifdef SRAM_REQ_WBUF_FWD_EN
                end else if (w_rd_pend) begin
                    w_rd_ready  = 1'b1;
                    w_fwd       = 1'b1;
`endif
                end else if (w_have_wr) begin
                    // Also the path for a conflicting read: drain oldest first.
                    w_state_nxt = ST_WR;
                    w_load_wr   = 1'b1;
                end
            end
            ST_RD: begin
                if (i_abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_addr_valid = 1'b1;
                    if (i_mem_read_finish) begin
                        w_rd_cap    = 1'b1;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_WR: begin
                w_addr_valid = 1'b1;
                if (i_mem_write_finish) w_state_nxt = ST_GAP;
            end
            default: w_state_nxt = ST_IDLE;   // ST_GAP: one idle cycle for the controller
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd_cap | w_fwd;
            if (w_load_rd) begin
                r_mem_addr <= w_rd_line;
                r_mem_we   <= 1'b0;
            end else if (w_load_wr) begin
                r_mem_addr  <= w_drain_addr;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_drain_data;
            end
            if (w_rd_cap)   r_rd_data <= i_mem_rdata;
            else if (w_fwd) r_rd_data <= w_fwd_data;
        end
    end

    assign o_rd_ready       = w_rd_ready;
    assign o_rd_valid       = r_rd_valid;
    assign o_rd_data        = r_rd_data;
    assign o_wr_ready       = ~w_full;
    assign o_wbuf_empty     = w_fifo_empty & (r_state != ST_WR);
    assign o_mem_addr_valid = w_addr_valid;
    assign o_mem_flush      = w_flush;
    assign o_mem_we         = r_mem_we;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_wdata      = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_line_requester.sv
// ============================================================================
//  Module   : tb_sram_line_requester
//  Purpose  : Directed self-checking bench for sram_line_requester with a
//             9-cycle SRAM controller model backed by a line store.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_line_requester;

    localparam int c_lat = 9;
`ifdef SRAM_REQ_WBUF_FWD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_rd_req = 1'b0;
    logic [19:0]  i_rd_addr = '0;
    logic         o_rd_ready, o_rd_valid;
    logic [255:0] o_rd_data;
    logic         i_wr_req = 1'b0;
    logic [19:0]  i_wr_addr = '0;
    logic [255:0] i_wr_data = '0;
    logic         o_wr_ready, i_abort = 1'b0, o_wbuf_empty;
    logic         o_mem_addr_valid, o_mem_we, o_mem_flush;
    logic [19:0]  o_mem_addr;
    logic [255:0] o_mem_wdata;
    logic         i_mem_read_finish = 1'b0, i_mem_write_finish = 1'b0;
    logic [255:0] i_mem_rdata = '0;

    always #5 clk = ~clk;

    sram_line_requester #(.WBUF_DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_rd_req           (i_rd_req),
        .i_rd_addr          (i_rd_addr),
        .o_rd_ready         (o_rd_ready),
        .o_rd_valid         (o_rd_valid),
        .o_rd_data          (o_rd_data),
        .i_wr_req           (i_wr_req),
        .i_wr_addr          (i_wr_addr),
        .i_wr_data          (i_wr_data),
        .o_wr_ready         (o_wr_ready),
        .i_abort            (i_abort),
        .o_wbuf_empty       (o_wbuf_empty),
        .o_mem_addr_valid   (o_mem_addr_valid),
        .o_mem_we           (o_mem_we),
        .o_mem_flush        (o_mem_flush),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wdata        (o_mem_wdata),
        .i_mem_read_finish  (i_mem_read_finish),
        .i_mem_write_finish (i_mem_write_finish),
        .i_mem_rdata        (i_mem_rdata)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, cnt = 0, n_wfin = 0, n_rdv = 0, n_gap_err = 0;
    logic         prev_fin = 1'b0;
    logic [20:0]  txn_log [$];          // {we, addr} of each transaction
    logic [255:0] mem_store [int];

    // Unwritten lines read back as {0xC0D, word address} per word.
    function automatic logic [255:0] pattern(input logic [19:0] base);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = {12'hC0D, base + 20'(k)};
        return v;
    endfunction

    function automatic logic [255:0] wdat(input int i);
        return {8{32'h1000_0000 + 32'(i)}};
    endfunction

    // Controller model: finish pulses c_lat cycles after addr_valid is first sampled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_rd_valid) n_rdv <= n_rdv + 1;
        if (prev_fin && o_mem_addr_valid) n_gap_err <= n_gap_err + 1;
        prev_fin <= i_mem_read_finish | i_mem_write_finish;
        if (i_mem_read_finish || i_mem_write_finish) begin
            if (i_mem_write_finish) n_wfin <= n_wfin + 1;
            i_mem_read_finish  <= 1'b0;
            i_mem_write_finish <= 1'b0;
            cnt <= 0;
        end else if (o_mem_addr_valid) begin
            if (cnt == 0) txn_log.push_back({o_mem_we, o_mem_addr});
            if (cnt == c_lat - 1) begin
                if (o_mem_we) begin
                    mem_store[int'(o_mem_addr)] = o_mem_wdata;
                    i_mem_write_finish <= 1'b1;
                end else begin
                    i_mem_read_finish <= 1'b1;
                    i_mem_rdata <= mem_store.exists(int'(o_mem_addr)) ?
                                   mem_store[int'(o_mem_addr)] : pattern(o_mem_addr);
                end
            end
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] log_at(input int idx);
        return (idx < txn_log.size()) ? txn_log[idx] : 21'h1F_FFFF;
    endfunction

    // Hold rd_req until accepted; any pending write is a single-cycle push.
    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            ok = o_rd_ready;
            @(posedge clk);
            #1;
            i_wr_req = 1'b0;
        end
        i_rd_req = 1'b0;
        check_eq({tag, " accept"}, 256'(ok), 256'(1));
    endtask

    task automatic issue_read(input string tag, input logic [19:0] a);
        i_rd_addr = a;
        i_rd_req  = 1'b1;
        wait_accept(tag);
    endtask

    task automatic wait_rd_valid(input string tag, input logic [255:0] exp, output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (o_rd_valid) begin
                seen = 1'b1;
                at   = cyc;
                check_eq({tag, " rd_data"}, o_rd_data, exp);
            end else begin
                tick();
            end
        end
        check_eq({tag, " rd_valid seen"}, 256'(seen), 256'(1));
    endtask

    task automatic wait_quiet(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = o_wbuf_empty && !o_mem_addr_valid;
        end
        check_eq({tag, " quiesce"}, 256'(ok), 256'(1));
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, rdv0;
        logic [255:0] d3;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst rd_ready",   256'(o_rd_ready), 256'(0));
        check_eq("rst rd_valid",   256'(o_rd_valid), 256'(0));
        check_eq("rst rd_data",    o_rd_data, 256'(0));
        check_eq("rst wr_ready",   256'(o_wr_ready), 256'(1));
        check_eq("rst wbuf_empty", 256'(o_wbuf_empty), 256'(1));
        check_eq("rst addr_valid", 256'(o_mem_addr_valid), 256'(0));
        check_eq("rst mem_we",     256'(o_mem_we), 256'(0));
        check_eq("rst mem_flush",  256'(o_mem_flush), 256'(0));
        check_eq("rst mem_addr",   256'(o_mem_addr), 256'(0));
        tick();

        // ---------------- t1: plain read, latency 11 ----------------
        t0 = cyc;
        i_rd_addr = 20'h00108;
        i_rd_req  = 1'b1;
        #1 check_eq("t1 rd_ready", 256'(o_rd_ready), 256'(1));
        tick();
        i_rd_req = 1'b0;
        check_eq("t1 addr_valid", 256'(o_mem_addr_valid), 256'(1));
        check_eq("t1 mem_we",     256'(o_mem_we), 256'(0));
        check_eq("t1 mem_addr",   256'(o_mem_addr), 256'(20'h00108));
        wait_rd_valid("t1", pattern(20'h00108), at);
        check_eq("t1 latency", 256'(at - t0), 256'(11));
        tick();
        check_eq("t1 rd_valid pulse", 256'(o_rd_valid), 256'(0));
        wait_quiet("t1");

        // ---------------- t2: fill buffer, drain in order ----------------
        txn_log.delete();
        for (int i = 0; i < 4; i++) begin
            i_wr_req  = 1'b1;
            i_wr_addr = 20'(8 * i);
            i_wr_data = wdat(i);
            if (i == 3) check_eq("t2 wr_ready before 4th", 256'(o_wr_ready), 256'(1));
            tick();
        end
        i_wr_req = 1'b0;
        check_eq("t2 wr_ready full",  256'(o_wr_ready), 256'(0));
        check_eq("t2 wbuf_empty busy", 256'(o_wbuf_empty), 256'(0));
        begin
            bit done = 1'b0;
            for (int i = 0; i < 400 && !done; i++) begin
                tick();
                done = (n_wfin >= 4);
            end
            check_eq("t2 four write finishes", 256'(done), 256'(1));
        end
        check_eq("t2 wbuf_empty after 4th", 256'(o_wbuf_empty), 256'(1));
        check_eq("t2 gap after 4th",        256'(o_mem_addr_valid), 256'(0));
        check_eq("t2 wr_ready after drain", 256'(o_wr_ready), 256'(1));
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t2 drain order %0d", i), 256'(log_at(i)), 256'({1'b1, 20'(8 * i)}));
        issue_read("t2 readback", 20'h00013);
        wait_rd_valid("t2 readback", wdat(2), at);
        wait_quiet("t2");

        // ---------------- t3: same-cycle write 0x40 + read 0x43 ----------------
        txn_log.delete();
        d3 = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
              32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0040};
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00040;
        i_wr_data = d3;
        i_rd_addr = 20'h00043;
        i_rd_req  = 1'b1;
        #1 check_eq("t3 same-cycle rd_ready", 256'(o_rd_ready), 256'(c_fwd));
        wait_accept("t3");
        wait_rd_valid("t3", d3, at);
        wait_quiet("t3");
        check_eq("t3 txn count", 256'(txn_log.size()), 256'(c_fwd ? 1 : 2));
        check_eq("t3 first txn", 256'(log_at(0)), 256'({1'b1, 20'h00040}));
        check_eq("t3 second txn", 256'(log_at(1)), c_fwd ? 256'(21'h1F_FFFF) : 256'({1'b0, 20'h00040}));

        // ---------------- t4: abort 4 cycles into a read ----------------
        txn_log.delete();
        rdv0 = n_rdv;
        issue_read("t4 a", 20'h00500);
        repeat (3) tick();
        i_abort = 1'b1;
        #1;
        check_eq("t4 flush",            256'(o_mem_flush), 256'(1));
        check_eq("t4 addr_valid abort", 256'(o_mem_addr_valid), 256'(0));
        tick();
        i_abort = 1'b0;
        #1;
        check_eq("t4 flush one cycle",  256'(o_mem_flush), 256'(0));
        check_eq("t4 addr_valid gap",   256'(o_mem_addr_valid), 256'(0));
        repeat (20) tick();
        check_eq("t4 no rd_valid", 256'(n_rdv - rdv0), 256'(0));
        issue_read("t4 b", 20'h00600);
        wait_rd_valid("t4 b", pattern(20'h00600), at);
        wait_quiet("t4");
        check_eq("t4 txn0", 256'(log_at(0)), 256'({1'b0, 20'h00500}));
        check_eq("t4 txn1", 256'(log_at(1)), 256'({1'b0, 20'h00600}));

        // ---------------- t5: reset mid-write ----------------
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00700;
        i_wr_data = wdat(7);
        tick();
        i_wr_req = 1'b0;
        check_eq("t5 in WR valid", 256'(o_mem_addr_valid), 256'(1));
        check_eq("t5 in WR we",    256'(o_mem_we), 256'(1));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_eq("t5 rst addr_valid", 256'(o_mem_addr_valid), 256'(0));
        check_eq("t5 rst wbuf_empty", 256'(o_wbuf_empty), 256'(1));
        check_eq("t5 rst wr_ready",   256'(o_wr_ready), 256'(1));
        rst = 1'b0;
        repeat (3) tick();

        // ---------------- t6: read beats a non-matching buffered write ----------------
        txn_log.delete();
        issue_read("t6 a", 20'h00800);
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00900;
        i_wr_data = wdat(9);
        i_rd_addr = 20'h00A00;
        i_rd_req  = 1'b1;
        wait_accept("t6 b");
        wait_rd_valid("t6 b", pattern(20'h00A00), at);
        wait_quiet("t6");
        check_eq("t6 txn0", 256'(log_at(0)), 256'({1'b0, 20'h00800}));
        check_eq("t6 txn1", 256'(log_at(1)), 256'({1'b0, 20'h00A00}));
        check_eq("t6 txn2", 256'(log_at(2)), 256'({1'b1, 20'h00900}));

        check_eq("gap cycle after every finish", 256'(n_gap_err), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
